debug_run_ctrl: RTL and testbench

- Run/step sequencer driving the CPU halt line; replaces switch-based step/run selection with a command interface for the debug host (UART bridge).
- Runs freely, steps N clock cycles or N instructions, halts on an address breakpoint at an instruction boundary, and reports each halt cause as a one-cycle event.
- Sits between the debug command decoder and the CPU control unit; o_halt feeds the same halt input as the clock block's halt output.

---
 rtl/debug_pkg.sv | 30 +++
 rtl/debug_bp_match.sv | 36 +++
 rtl/debug_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_debug_run_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared encodings for the debug run/step sequencer: states, command codes,
// halt-event causes and default widths.
package debug_pkg;

  localparam int DEFAULT_COUNT_W = 16;
  localparam int DEFAULT_ADDR_W  = 16;

  typedef enum logic [1:0] {
    ST_HALTED     = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP_CYC   = 2'd2,
    ST_STEP_INSTR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_RUN        = 3'd1,
    CMD_HALT       = 3'd2,
    CMD_STEP_CYC   = 3'd3,
    CMD_STEP_INSTR = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    CAUSE_HALT_CMD   = 2'd0,
    CAUSE_STEP_DONE  = 2'd1,
    CAUSE_BREAKPOINT = 2'd2,
    CAUSE_REJECTED   = 2'd3
  } cause_t;

endpackage

// File: rtl/debug_bp_match.sv
// Address breakpoint comparator with a skip flag that ignores the first
// instruction boundary after resuming from a breakpoint halt.
module debug_bp_match
  import debug_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_halt,
  input  logic              i_ctrlInstrFinishedN,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_bpAddr,
  input  logic              i_bpEnableN,
  input  logic              i_setSkip,
  output logic              o_match
);

  logic r_skip;
  logic w_boundary;

  assign w_boundary = !i_halt && !i_ctrlInstrFinishedN;
  assign o_match    = w_boundary && !i_bpEnableN && (i_pc == i_bpAddr) && !r_skip;

  // The boundary that clears the skip flag is itself suppressed above.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_skip <= 1'b0;
    end else if (i_setSkip) begin
      r_skip <= 1'b1;
    end else if (w_boundary) begin
      r_skip <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_run_ctrl.sv
// Run/step sequencer driving the CPU halt line from debug-host commands.
// Define DEBUG_RUN_CYCLE_COUNTER_EN to add the o_runCycles unhalted-cycle counter.
module debug_run_ctrl
  import debug_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_cmdValid,
  output logic               o_cmdReady,
  input  logic [2:0]         i_cmd,
  input  logic [COUNT_W-1:0] i_cmdArg,
  input  logic               i_ctrlInstrFinishedN,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [ADDR_W-1:0]  i_bpAddr,
  input  logic               i_bpEnableN,
  output logic               o_halt,
  output logic [1:0]         o_state,
  output logic [COUNT_W-1:0] o_remaining,
  output logic               o_evtValid,
  output logic [1:0]         o_evtCause
`ifdef DEBUG_RUN_CYCLE_COUNTER_EN
  ,
  output logic [31:0]        o_runCycles
`endif
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             r_state, w_nextState;
  logic               r_halt, w_nextHalt;
  logic [COUNT_W-1:0] r_remaining, w_nextRemaining;
  logic               r_evtValid, w_nextEvtValid;
  cause_t             r_evtCause, w_nextEvtCause;
  logic               r_lastBp, w_nextLastBp;
  logic               w_setSkip;
  logic               w_match;
  logic               w_isGo;
  logic               w_boundary;

  assign o_cmdReady  = i_resetn;
  assign o_halt      = r_halt;
  assign o_state     = r_state;
  assign o_remaining = r_remaining;
  assign o_evtValid  = r_evtValid;
  assign o_evtCause  = r_evtCause;

  assign w_isGo     = (i_cmd == CMD_RUN) || (i_cmd == CMD_STEP_CYC) || (i_cmd == CMD_STEP_INSTR);
  assign w_boundary = !r_halt && !i_ctrlInstrFinishedN;

  debug_bp_match #(.ADDR_W(ADDR_W)) u_bpMatch (
    .i_clk                (i_clk),
    .i_resetn             (i_resetn),
    .i_halt               (r_halt),
    .i_ctrlInstrFinishedN (i_ctrlInstrFinishedN),
    .i_pc                 (i_pc),
    .i_bpAddr             (i_bpAddr),
    .i_bpEnableN          (i_bpEnableN),
    .i_setSkip            (w_setSkip),
    .o_match              (w_match)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= ST_HALTED;
      r_halt      <= 1'b1;
      r_remaining <= '0;
      r_evtValid  <= 1'b0;
      r_evtCause  <= CAUSE_HALT_CMD;
      r_lastBp    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_halt      <= w_nextHalt;
      r_remaining <= w_nextRemaining;
      r_evtValid  <= w_nextEvtValid;
      r_evtCause  <= w_nextEvtCause;
      r_lastBp    <= w_nextLastBp;
    end
  end

  // Halt sources are prioritised HALT command, then breakpoint, then step end;
  // a rejected command only reports when nothing else did this cycle.
  always_comb begin
    w_nextState     = r_state;
    w_nextHalt      = r_halt;
    w_nextRemaining = r_remaining;
    w_nextEvtValid  = 1'b0;
    w_nextEvtCause  = r_evtCause;
    w_nextLastBp    = r_lastBp;
    w_setSkip       = 1'b0;
    if (r_state == ST_HALTED) begin
      if (i_cmdValid) begin
        case (i_cmd)
          CMD_RUN: begin
            w_nextState = ST_RUN;
            w_nextHalt  = 1'b0;
            w_setSkip   = r_lastBp;
          end
          CMD_STEP_CYC, CMD_STEP_INSTR: begin
            if (i_cmdArg == '0) begin
              w_nextEvtValid = 1'b1;
              w_nextEvtCause = CAUSE_STEP_DONE;
              w_nextLastBp   = 1'b0;
            end else begin
              w_nextState     = (i_cmd == CMD_STEP_CYC) ? ST_STEP_CYC : ST_STEP_INSTR;
              w_nextHalt      = 1'b0;
              w_nextRemaining = i_cmdArg;
              w_setSkip       = r_lastBp;
            end
          end
          default: ;
        endcase
      end
    end else if (i_cmdValid && (i_cmd == CMD_HALT)) begin
      w_nextState    = ST_HALTED;
      w_nextHalt     = 1'b1;
      w_nextEvtValid = 1'b1;
      w_nextEvtCause = CAUSE_HALT_CMD;
      w_nextLastBp   = 1'b0;
    end else if (w_match) begin
      w_nextState    = ST_HALTED;
      w_nextHalt     = 1'b1;
      w_nextEvtValid = 1'b1;
      w_nextEvtCause = CAUSE_BREAKPOINT;
      w_nextLastBp   = 1'b1;
    end else begin
      if ((r_state == ST_STEP_CYC && r_remaining == ONE) ||
          (r_state == ST_STEP_INSTR && r_remaining == '0)) begin
        w_nextState     = ST_HALTED;
        w_nextHalt      = 1'b1;
        w_nextRemaining = '0;
        w_nextEvtValid  = 1'b1;
        w_nextEvtCause  = CAUSE_STEP_DONE;
        w_nextLastBp    = 1'b0;
      end else if (r_remaining != '0 &&
                   (r_state == ST_STEP_CYC || (r_state == ST_STEP_INSTR && w_boundary))) begin
        w_nextRemaining = r_remaining - ONE;
      end
      if (!w_nextEvtValid && i_cmdValid && w_isGo) begin
        w_nextEvtValid = 1'b1;
        w_nextEvtCause = CAUSE_REJECTED;
      end
    end
  end

`ifdef DEBUG_RUN_CYCLE_COUNTER_EN
  logic [31:0] r_runCycles;
  logic        w_clrRun;

  assign w_clrRun    = (r_state == ST_HALTED) && i_cmdValid && w_isGo;
  assign o_runCycles = r_runCycles;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_runCycles <= '0;
    end else if (w_clrRun) begin
      r_runCycles <= '0;
    end else if (!r_halt) begin
      r_runCycles <= r_runCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed self-checking bench for debug_run_ctrl: stepping, breakpoints with
// skip-on-resume, command rejection, event priority and reset abort.
module tb_debug_run_ctrl;

  logic        i_clk = 1'b0;
  logic        i_resetn;
  logic        i_cmdValid;
  logic        o_cmdReady;
  logic [2:0]  i_cmd;
  logic [15:0] i_cmdArg;
  logic        i_ctrlInstrFinishedN;
  logic [15:0] i_pc;
  logic [15:0] i_bpAddr;
  logic        i_bpEnableN;
  logic        o_halt;
  logic [1:0]  o_state;
  logic [15:0] o_remaining;
  logic        o_evtValid;
  logic [1:0]  o_evtCause;
`ifdef DEBUG_RUN_CYCLE_COUNTER_EN
  logic [31:0] o_runCycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  debug_run_ctrl dut (
    .i_clk                (i_clk),
    .i_resetn             (i_resetn),
    .i_cmdValid           (i_cmdValid),
    .o_cmdReady           (o_cmdReady),
    .i_cmd                (i_cmd),
    .i_cmdArg             (i_cmdArg),
    .i_ctrlInstrFinishedN (i_ctrlInstrFinishedN),
    .i_pc                 (i_pc),
    .i_bpAddr             (i_bpAddr),
    .i_bpEnableN          (i_bpEnableN),
    .o_halt               (o_halt),
    .o_state              (o_state),
    .o_remaining          (o_remaining),
    .o_evtValid           (o_evtValid),
    .o_evtCause           (o_evtCause)
`ifdef DEBUG_RUN_CYCLE_COUNTER_EN
    ,
    .o_runCycles          (o_runCycles)
`endif
  );

  // Advance one cycle; outputs are then stable and inputs apply to the new cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [15:0] arg);
    i_cmdValid = 1'b1;
    i_cmd      = cmd;
    i_cmdArg   = arg;
    tick();
    i_cmdValid = 1'b0;
    i_cmd      = 3'd0;
    i_cmdArg   = '0;
  endtask

  task automatic test_reset();
    i_resetn = 1'b0; i_cmdValid = 1'b0; i_cmd = 3'd0; i_cmdArg = '0;
    i_ctrlInstrFinishedN = 1'b1; i_pc = '0; i_bpAddr = '0; i_bpEnableN = 1'b1;
    tick(); tick();
    total++; if (o_halt !== 1'b1) begin bad++; $display("[TB] FAIL reset_halt got=%b want=1", o_halt); end
    total++; if (o_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", o_state); end
    total++; if (o_remaining !== 16'd0) begin bad++; $display("[TB] FAIL reset_rem got=%0d want=0", o_remaining); end
    total++; if (o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_evt got=%b want=0", o_evtValid); end
    total++; if (o_evtCause !== 2'd0) begin bad++; $display("[TB] FAIL reset_cause got=%0d want=0", o_evtCause); end
    i_resetn = 1'b1;
    tick();
    total++; if (o_cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL ready got=%b want=1", o_cmdReady); end
  endtask

  task automatic test_step_zero();
    issue(3'd3, 16'd0);
    total++; if (o_halt !== 1'b1 || o_state !== 2'd0) begin bad++; $display("[TB] FAIL stepcyc0_state got=%b/%0d want=1/0", o_halt, o_state); end
    total++; if (o_evtValid !== 1'b1 || o_evtCause !== 2'd1) begin bad++; $display("[TB] FAIL stepcyc0_evt got=%b/%0d want=1/1", o_evtValid, o_evtCause); end
    issue(3'd4, 16'd0);
    total++; if (o_halt !== 1'b1 || o_evtValid !== 1'b1 || o_evtCause !== 2'd1) begin bad++; $display("[TB] FAIL stepinstr0 got=%b/%b/%0d want=1/1/1", o_halt, o_evtValid, o_evtCause); end
    issue(3'd2, 16'd0);
    total++; if (o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL halt_when_halted_evt got=%b want=0", o_evtValid); end
  endtask

  task automatic test_step_cyc();
    issue(3'd3, 16'd3);
    for (int i = 0; i < 3; i++) begin
      total++; if (o_halt !== 1'b0 || o_remaining !== 16'(3 - i)) begin bad++; $display("[TB] FAIL stepcyc_c%0d got=%b/%0d want=0/%0d", i + 1, o_halt, o_remaining, 3 - i); end
      total++; if (o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL stepcyc_noevt_c%0d got=%b want=0", i + 1, o_evtValid); end
      tick();
    end
    total++; if (o_halt !== 1'b1 || o_state !== 2'd0 || o_remaining !== 16'd0) begin bad++; $display("[TB] FAIL stepcyc_end got=%b/%0d/%0d want=1/0/0", o_halt, o_state, o_remaining); end
    total++; if (o_evtValid !== 1'b1 || o_evtCause !== 2'd1) begin bad++; $display("[TB] FAIL stepcyc_evt got=%b/%0d want=1/1", o_evtValid, o_evtCause); end
`ifdef DEBUG_RUN_CYCLE_COUNTER_EN
    total++; if (o_runCycles !== 32'd3) begin bad++; $display("[TB] FAIL runcycles got=%0d want=3", o_runCycles); end
`endif
    tick();
    total++; if (o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL stepcyc_evt_once got=%b want=0", o_evtValid); end
  endtask

  task automatic test_step_instr();
    i_pc = 16'h0100;
    issue(3'd4, 16'd2);
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin
        total++; if (o_state !== 2'd3 || o_remaining !== 16'd2 || o_halt !== 1'b0) begin bad++; $display("[TB] FAIL stepinstr_start got=%0d/%0d/%b want=3/2/0", o_state, o_remaining, o_halt); end
      end
      if (c == 5) begin
        total++; if (o_remaining !== 16'd1 || o_state !== 2'd3) begin bad++; $display("[TB] FAIL stepinstr_mid got=%0d/%0d want=1/3", o_remaining, o_state); end
      end
      if (c == 9) begin
        total++; if (o_remaining !== 16'd0 || o_halt !== 1'b0 || o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL stepinstr_zero got=%0d/%b/%b want=0/0/0", o_remaining, o_halt, o_evtValid); end
      end
      if (c == 10) begin
        total++; if (o_halt !== 1'b1 || o_state !== 2'd0 || o_evtValid !== 1'b1 || o_evtCause !== 2'd1) begin bad++; $display("[TB] FAIL stepinstr_end got=%b/%0d/%b/%0d want=1/0/1/1", o_halt, o_state, o_evtValid, o_evtCause); end
      end
      i_ctrlInstrFinishedN = (c % 4 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    i_ctrlInstrFinishedN = 1'b1;
  endtask

  task automatic test_breakpoint();
    i_bpAddr = 16'h0010; i_bpEnableN = 1'b0; i_pc = 16'h0000;
    for (int pass = 0; pass < 2; pass++) begin
      issue(3'd1, 16'd0);
      for (int c = 1; c <= 5; c++) begin
        if (c == 1) begin
          total++; if (o_state !== 2'd1 || o_halt !== 1'b0) begin bad++; $display("[TB] FAIL bp_run%0d got=%0d/%b want=1/0", pass, o_state, o_halt); end
        end
        if (c == 3) begin
          total++; if (o_halt !== 1'b0 || o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_early%0d got=%b/%b want=0/0", pass, o_halt, o_evtValid); end
        end
        if (c == 5) begin
          total++; if (o_halt !== 1'b1 || o_state !== 2'd0 || o_evtValid !== 1'b1 || o_evtCause !== 2'd2) begin bad++; $display("[TB] FAIL bp_hit%0d got=%b/%0d/%b/%0d want=1/0/1/2", pass, o_halt, o_state, o_evtValid, o_evtCause); end
        end
        i_ctrlInstrFinishedN = (c == 2 || c == 4) ? 1'b0 : 1'b1;
        i_pc = (pass == 0 && c == 2) ? 16'h000C : 16'h0010;
        tick();
      end
      i_ctrlInstrFinishedN = 1'b1;
    end
    i_bpEnableN = 1'b1;
  endtask

  task automatic test_reject();
    issue(3'd1, 16'd0);
    total++; if (o_state !== 2'd1) begin bad++; $display("[TB] FAIL rej_run got=%0d want=1", o_state); end
    i_ctrlInstrFinishedN = 1'b0;
    tick();
    i_ctrlInstrFinishedN = 1'b1;
    issue(3'd3, 16'd5);
    total++; if (o_evtValid !== 1'b1 || o_evtCause !== 2'd3) begin bad++; $display("[TB] FAIL rej_evt got=%b/%0d want=1/3", o_evtValid, o_evtCause); end
    total++; if (o_state !== 2'd1 || o_halt !== 1'b0 || o_remaining !== 16'd0) begin bad++; $display("[TB] FAIL rej_keep got=%0d/%b/%0d want=1/0/0", o_state, o_halt, o_remaining); end
    issue(3'd2, 16'd0);
    total++; if (o_halt !== 1'b1 || o_state !== 2'd0 || o_evtValid !== 1'b1 || o_evtCause !== 2'd0) begin bad++; $display("[TB] FAIL halt_cmd got=%b/%0d/%b/%0d want=1/0/1/0", o_halt, o_state, o_evtValid, o_evtCause); end
    issue(3'd2, 16'd0);
    total++; if (o_evtValid !== 1'b0 || o_state !== 2'd0) begin bad++; $display("[TB] FAIL halt_again got=%b/%0d want=0/0", o_evtValid, o_state); end
  endtask

  task automatic test_priority();
    i_bpAddr = 16'h0020; i_bpEnableN = 1'b0; i_pc = 16'h0020;
    issue(3'd3, 16'd2);
    tick();
    total++; if (o_remaining !== 16'd1) begin bad++; $display("[TB] FAIL prio_last got=%0d want=1", o_remaining); end
    i_ctrlInstrFinishedN = 1'b0;
    issue(3'd2, 16'd0);
    i_ctrlInstrFinishedN = 1'b1;
    total++; if (o_halt !== 1'b1 || o_evtValid !== 1'b1 || o_evtCause !== 2'd0) begin bad++; $display("[TB] FAIL prio_halt got=%b/%b/%0d want=1/1/0", o_halt, o_evtValid, o_evtCause); end
    tick();
    total++; if (o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL prio_single got=%b want=0", o_evtValid); end
    issue(3'd3, 16'd1);
    i_ctrlInstrFinishedN = 1'b0;
    tick();
    i_ctrlInstrFinishedN = 1'b1;
    total++; if (o_halt !== 1'b1 || o_evtCause !== 2'd2 || o_remaining !== 16'd1) begin bad++; $display("[TB] FAIL prio_bp_over_step got=%b/%0d/%0d want=1/2/1", o_halt, o_evtCause, o_remaining); end
    i_bpEnableN = 1'b1;
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 16'd7);
    total++; if (o_remaining !== 16'd7 || o_state !== 2'd3) begin bad++; $display("[TB] FAIL mid_load got=%0d/%0d want=7/3", o_remaining, o_state); end
    i_resetn = 1'b0;
    tick();
    total++; if (o_state !== 2'd0 || o_halt !== 1'b1 || o_remaining !== 16'd0 || o_evtValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset got=%0d/%b/%0d/%b want=0/1/0/0", o_state, o_halt, o_remaining, o_evtValid); end
    total++; if (o_cmdReady !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready got=%b want=0", o_cmdReady); end
    i_resetn = 1'b1;
    tick();
    total++; if (o_evtValid !== 1'b0 || o_halt !== 1'b1) begin bad++; $display("[TB] FAIL mid_after got=%b/%b want=0/1", o_evtValid, o_halt); end
  endtask

  initial begin
    test_reset();
    test_step_zero();
    test_step_cyc();
    test_step_instr();
    test_breakpoint();
    test_reject();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
